div: RTL and testbench

Sequential 16-by-8 unsigned restoring divider, the inverse companion of the team's shift-add multiplier. Accepts a 16-bit dividend and an 8-bit divisor on a start/busy handshake and produces one quotient bit per clock. It has the same operand/result handshake style as the multiplier, so both arithmetic units can sit behind the same control logic. Divide-by-zero is detected up front and flagged, never iterated.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 27 ++
 rtl/div.sv | 121 ++++++++++++
 tb/tb_div.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WORK = 1'b1
   } state_t;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 8;
   localparam int STEPS      = 16;
   localparam int CTR_W      = 5;

   // Quotient reported when the divisor is zero
   localparam logic [DIVIDEND_W-1:0] DIVZERO_Q = 16'hFFFF;

   // Counter value of the final iteration
   localparam logic [CTR_W-1:0] LAST_STEP = CTR_W'(STEPS - 1);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
   import div_pkg::*;
(
   input  logic [DIVISOR_W-1:0] pr,
   input  logic                 dq_msb,
   input  logic [DIVISOR_W-1:0] d,
   output logic [DIVISOR_W-1:0] pr_next,
   output logic                 qbit
);

   logic [DIVISOR_W:0]   t;
   logic [DIVISOR_W-1:0] diff;

   // Trial subtraction; the difference is always below d, so the low bits hold it exactly
   always_comb begin
      t       = {pr, dq_msb};
      diff    = t[DIVISOR_W-1:0] - d;
      pr_next = t[DIVISOR_W-1:0];
      qbit    = 1'b0;
      if (t >= {1'b0, d}) begin
         pr_next = diff;
         qbit    = 1'b1;
      end
   end

endmodule

// File: rtl/div.sv
// 16-by-8 unsigned restoring divider, one quotient bit per clock, start/busy handshake.
module div
   import div_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DIVIDEND_W-1:0] a_bi,
   input  logic [DIVISOR_W-1:0]  b_bi,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DIVIDEND_W-1:0] q_bo,
   output logic [DIVISOR_W-1:0]  r_bo,
   output logic                  err_o
);

   state_t state_q, state_d;

   // Partial remainder is kept at divisor width: it is always strictly below d,
   // and the extra shifted-in bit only exists transiently inside div_step.
   logic [DIVIDEND_W-1:0] dq;
   logic [DIVISOR_W-1:0]  d;
   logic [DIVISOR_W-1:0]  pr;
   logic [CTR_W-1:0]      ctr;

   logic [DIVISOR_W-1:0]  pr_next;
   logic                  qbit;

   logic                  accept;
   logic                  divzero;
   logic                  finish;

   div_step u_step (
      .pr      (pr),
      .dq_msb  (dq[DIVIDEND_W-1]),
      .d       (d),
      .pr_next (pr_next),
      .qbit    (qbit)
   );

   assign busy_o = (state_q == WORK);

   // Next-state logic and handshake decode
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      divzero = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (b_bi == '0) begin
                  divzero = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = WORK;
               end
            end
         end
         WORK: begin
            if (ctr == LAST_STEP) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Iteration datapath: load operands on accept, shift/subtract while working
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dq  <= '0;
         d   <= '0;
         pr  <= '0;
         ctr <= '0;
      end else if (accept) begin
         dq  <= a_bi;
         d   <= b_bi;
         pr  <= '0;
         ctr <= '0;
      end else if (state_q == WORK) begin
         dq  <= {dq[DIVIDEND_W-2:0], qbit};
         pr  <= pr_next;
         ctr <= ctr + 1'b1;
      end
   end

   // Result registers and one-cycle completion pulse
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_bo   <= '0;
         r_bo   <= '0;
         err_o  <= 1'b0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (divzero) begin
            q_bo   <= DIVZERO_Q;
            r_bo   <= a_bi[DIVISOR_W-1:0];
            err_o  <= 1'b1;
            done_o <= 1'b1;
         end else if (finish) begin
            q_bo   <= {dq[DIVIDEND_W-2:0], qbit};
            r_bo   <= pr_next;
            err_o  <= 1'b0;
            done_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the sequential divider: driver pushes expectations, monitor checks on done_o.
module tb_div;

   logic        clk_i;
   logic        rst_i;
   logic [15:0] a_bi;
   logic [7:0]  b_bi;
   logic        start_i;
   logic        busy_o;
   logic        done_o;
   logic [15:0] q_bo;
   logic [7:0]  r_bo;
   logic        err_o;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   div dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .a_bi    (a_bi),
      .b_bi    (b_bi),
      .start_i (start_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .q_bo    (q_bo),
      .r_bo    (r_bo),
      .err_o   (err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every completion pulse must match the oldest outstanding expectation
   always @(negedge clk_i) begin
      if (!rst_i && done_o) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got q=%0d r=%0d err=%0d, expected no completion",
                     q_bo, r_bo, err_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("q", int'(q_bo), int'(e.q));
            chk("r", int'(r_bo), int'(e.r));
            chk("err", int'(err_o), int'(e.err));
         end
      end
   end

   // Wait (bounded) until the divider is idle, then present one request for one edge.
   task automatic issue(input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input logic ee);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk_i);
      while (busy_o && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      if (busy_o) chk("idle_timeout", 1, 0);
      a_bi    = a;
      b_bi    = b;
      start_i = 1'b1;
      e.q = eq; e.r = er; e.err = ee;
      sb.push_back(e);
      @(posedge clk_i);
      #1 start_i = 1'b0;
   endtask

   // Count busy cycles until done_o, bounded
   task automatic count_busy(output int cyc);
      int n;
      cyc = 0;
      n   = 0;
      @(negedge clk_i);
      while (!done_o && n < 40) begin
         if (busy_o) cyc++;
         @(negedge clk_i);
         n++;
      end
      if (!done_o) chk("done_timeout", 1, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy_o) && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk("drain_pending", sb.size(), 0);
   endtask

   initial begin
      int          cyc;
      logic [15:0] ra;
      logic [7:0]  rb;

      rst_i   = 1'b1;
      start_i = 1'b0;
      a_bi    = '0;
      b_bi    = '0;
      repeat (2) @(negedge clk_i);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_q", q_bo, 0);
      chk("rst_r", r_bo, 0);
      chk("rst_err", err_o, 0);
      rst_i = 1'b0;

      // Basic division with latency measurement
      issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
      count_busy(cyc);
      chk("busy_cycles", cyc, 16);
      @(negedge clk_i);
      chk("done_pulse_len", done_o, 0);

      // Corner values back-to-back, each start in the preceding done cycle
      issue(16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0);
      issue(16'd65535, 8'd255, 16'd257,   8'd0,  1'b0);
      issue(16'd0,     8'd5,   16'd0,     8'd0,  1'b0);
      issue(16'd12345, 8'd100, 16'd123,   8'd45, 1'b0);
      drain();

      // Divide by zero completes on the accepting edge without busy
      issue(16'd100, 8'd0, 16'hFFFF, 8'd100, 1'b1);
      chk("divzero_done", done_o, 1);
      chk("divzero_busy", busy_o, 0);
      @(negedge clk_i);
      chk("divzero_busy_after", busy_o, 0);
      issue(16'd10, 8'd3, 16'd3, 8'd1, 1'b0);
      drain();

      // A start while busy is ignored
      issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
      repeat (4) @(negedge clk_i);
      a_bi    = 16'd9;
      b_bi    = 8'd3;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      drain();
      @(negedge clk_i);
      chk("ignored_start_busy", busy_o, 0);

      // Asynchronous reset in the middle of a division
      issue(16'd1000, 8'd7, 16'd0, 8'd0, 1'b0);
      void'(sb.pop_back());
      repeat (7) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_q", q_bo, 0);
      chk("midrst_r", r_bo, 0);
      chk("midrst_err", err_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      issue(16'd200, 8'd9, 16'd22, 8'd2, 1'b0);
      drain();

      // Short randomized sweep against the arithmetic definition
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = (i % 8 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         if (rb == 0) issue(ra, rb, 16'hFFFF, ra[7:0], 1'b1);
         else         issue(ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
